exc_sched: RTL and testbench
============================

EXC_SCHED -- requirements
Module: exc_sched

Interface
REQ-001 Parameter NUM_IRQ, default 6, number of external interrupt lines (1..8).
REQ-002 Parameter ACK_WAIT, default 0, reserved; SHALL be ignored by the logic.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 inst_valid  in  1  current instruction valid this cycle.
REQ-006 pc  in  32  address of current instruction.
REQ-007 syscall, brk, teq_hit  in  1 each  synchronous exception flags, qualified by inst_valid.
REQ-008 mtc0_req, eret_req  in  1 each  core requests a CP0 write or an exception return.
REQ-009 irq  in  NUM_IRQ  external interrupt lines.
REQ-010 status  in  32  CP0 status copy; bit0 global IE, bit1 SYSCALL enable, bit2 BREAK enable, bit3 TEQ enable, bits[8+NUM_IRQ-1:8] IRQ mask.
REQ-011 cp0_ack  in  1  CP0 has committed the entry write.
REQ-012 stall  out  1  core holds its PC and does not retire.
REQ-013 exc_valid  out  1  entry request to CP0, held until acked.
REQ-014 exc_cause  out  5  cause code: 0 = INT, 8 = SYS, 9 = BP, 13 = TR.
REQ-015 exc_irq  out  3  index of the serviced interrupt; 0 for synchronous causes.
REQ-016 exc_epc  out  32  PC captured at exception detection.
REQ-017 mtc0_go, eret_go  out  1 each  granted one-cycle strobes to CP0.
REQ-018 in_service  out  1  handler active (set on entry, cleared on eret).

Function
REQ-019 FSM states SHALL be IDLE, ENTRY, FLUSH.
REQ-020 A synchronous event SHALL be inst_valid & status[0] & flag & enable bit; priority SYS > BP > TR.
REQ-021 An interrupt event SHALL be pending[i] & status[8+i] & status[0] & !in_service; lowest index wins; synchronous events beat interrupts.
REQ-022 In IDLE with an event at cycle N, stall SHALL be 1 combinationally in N; exc_valid/exc_cause/exc_irq/exc_epc SHALL be registered, valid from N+1; state becomes ENTRY.
REQ-023 In ENTRY, exc_valid and all exc_* outputs SHALL hold stable; cp0_ack sampled high moves to FLUSH, clears exc_valid, sets in_service, and clears pending of the serviced IRQ.
REQ-024 FLUSH SHALL last exactly one cycle with stall = 1, then return to IDLE.
REQ-025 stall SHALL be 1 in ENTRY and FLUSH regardless of other inputs.
REQ-026 mtc0_go/eret_go SHALL pulse in the same cycle as the request only in IDLE with no event; otherwise the request is stalled (stall = 1) and re-evaluated every cycle.
REQ-027 An event in the same cycle as mtc0_req or eret_req SHALL win; the strobe stays 0.
REQ-028 eret_go SHALL clear in_service on the next edge; eret_req with in_service = 0 still pulses eret_go.
REQ-029 Events arriving outside IDLE SHALL not be lost if level/pending; synchronous flags are re-sampled once stall releases.
REQ-030 cp0_ack outside ENTRY SHALL be ignored.

Reset
REQ-031 While rst = 0: state IDLE, pending = 0, in_service = 0, all outputs 0 (stall = 0, exc_cause = 0, exc_epc = 0), regardless of clk.
REQ-032 Reset asserted in ENTRY or FLUSH SHALL abort the entry; no strobe is emitted in the first cycle after release.

Configuration
REQ-033 Macro EXC_IRQ_EDGE_EN defined: pending[i] SHALL be set on a 0->1 edge of irq[i] (one-cycle delayed sample) and cleared only on service.
REQ-034 EXC_IRQ_EDGE_EN undefined: pending SHALL equal irq directly (level-sensitive); no edge registers exist.

Verification
REQ-035 status = 0x3, syscall = 1, pc = 0x0040_0010 at N -> stall = 1 at N; exc_valid = 1, cause = 8, epc = 0x0040_0010 at N+1; ack at N+3 -> FLUSH at N+4, IDLE at N+5, in_service = 1.
REQ-036 syscall and brk both 1 with status = 0x7 -> cause = 8; with status = 0x5 -> cause = 9.
REQ-037 status = 0x0000_0A01, irq = 6'b001010 -> cause = 0, exc_irq = 1; irq[3] is serviced only after eret_go clears in_service.
REQ-038 mtc0_req = 1 and teq_hit = 1 with status = 0x9 in IDLE -> mtc0_go = 0, cause = 13; mtc0_go pulses in the first IDLE cycle after FLUSH.
REQ-039 rst driven to 0 mid-ENTRY with no clk edge -> all outputs 0 immediately; after release, no exc_valid without a new event.
REQ-040 With EXC_IRQ_EDGE_EN, irq[0] held high across service -> exactly one entry; without it -> re-entry after eret.

Source files
------------

// File: rtl/exc_sched_if.sv
// Core/CP0 <-> exception scheduler signal bundle.
// master: core and CP0 side, slave: the scheduler.
interface exc_sched_if #(
    parameter int NUM_IRQ = 6
);
    logic               inst_valid;
    logic [31:0]        pc;
    logic               syscall;
    logic               brk;
    logic               teq_hit;
    logic               mtc0_req;
    logic               eret_req;
    logic [NUM_IRQ-1:0] irq;
    logic [31:0]        status;
    logic               cp0_ack;
    logic               stall;
    logic               exc_valid;
    logic [4:0]         exc_cause;
    logic [2:0]         exc_irq;
    logic [31:0]        exc_epc;
    logic               mtc0_go;
    logic               eret_go;
    logic               in_service;

    modport master (
        output inst_valid, pc, syscall, brk, teq_hit, mtc0_req, eret_req, irq, status, cp0_ack,
        input  stall, exc_valid, exc_cause, exc_irq, exc_epc, mtc0_go, eret_go, in_service
    );

    modport slave (
        input  inst_valid, pc, syscall, brk, teq_hit, mtc0_req, eret_req, irq, status, cp0_ack,
        output stall, exc_valid, exc_cause, exc_irq, exc_epc, mtc0_go, eret_go, in_service
    );
endinterface

// File: rtl/exc_sched.sv
// exc_sched: sequences exception/interrupt entry into CP0 and arbitrates mtc0/eret strobes.
// Build option EXC_IRQ_EDGE_EN: edge-latched interrupt pending bits (default: level-sensitive).
module exc_sched #(
    parameter int NUM_IRQ  = 6,
    parameter int ACK_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    exc_sched_if.slave bus
);
    localparam logic [4:0] CAUSE_INT = 5'd0;
    localparam logic [4:0] CAUSE_SYS = 5'd8;
    localparam logic [4:0] CAUSE_BP  = 5'd9;
    localparam logic [4:0] CAUSE_TR  = 5'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               exc_valid_q, exc_valid_d;
    logic [4:0]         exc_cause_q, exc_cause_d;
    logic [2:0]         exc_irq_q, exc_irq_d;
    logic [31:0]        exc_epc_q, exc_epc_d;
    logic               in_service_q, in_service_d;
    logic               armed_q, armed_d;
    logic [NUM_IRQ-1:0] pending_s;
    logic [NUM_IRQ-1:0] irq_ev_s;
    logic               sys_ev_s, bp_ev_s, tr_ev_s, sync_ev_s, event_s;
    logic               req_s, ack_take_s;
    logic [4:0]         sync_cause_s;
    logic [2:0]         irq_idx_s;
    logic               stall_s, mtc0_go_s, eret_go_s;

    // ACK_WAIT is reserved and deliberately has no effect on the logic.
    if (ACK_WAIT < 0) begin : g_ack_wait_reserved
    end

    // Decode synchronous and interrupt events and select the winning source.
    always_comb begin
        sys_ev_s  = bus.inst_valid & bus.status[0] & bus.syscall & bus.status[1];
        bp_ev_s   = bus.inst_valid & bus.status[0] & bus.brk     & bus.status[2];
        tr_ev_s   = bus.inst_valid & bus.status[0] & bus.teq_hit & bus.status[3];
        sync_ev_s = sys_ev_s | bp_ev_s | tr_ev_s;
        if (sys_ev_s) begin
            sync_cause_s = CAUSE_SYS;
        end else if (bp_ev_s) begin
            sync_cause_s = CAUSE_BP;
        end else if (tr_ev_s) begin
            sync_cause_s = CAUSE_TR;
        end else begin
            sync_cause_s = CAUSE_INT;
        end
        irq_ev_s  = pending_s & bus.status[8 +: NUM_IRQ] & {NUM_IRQ{bus.status[0] & ~in_service_q}};
        irq_idx_s = 3'd0;
        // Scan downward so the lowest active index is the one left standing.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_ev_s[i]) begin
                irq_idx_s = 3'(i);
            end else begin
                irq_idx_s = irq_idx_s;
            end
        end
        event_s    = sync_ev_s | (|irq_ev_s);
        req_s      = bus.mtc0_req | bus.eret_req;
        ack_take_s = (state_q == ENTRY) & bus.cp0_ack;
    end

    // Next-state and strobe logic of the entry sequencer.
    always_comb begin
        state_d      = state_q;
        exc_valid_d  = exc_valid_q;
        exc_cause_d  = exc_cause_q;
        exc_irq_d    = exc_irq_q;
        exc_epc_d    = exc_epc_q;
        in_service_d = in_service_q;
        armed_d      = 1'b1;
        stall_s      = 1'b0;
        mtc0_go_s    = 1'b0;
        eret_go_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (event_s) begin
                    stall_s     = 1'b1;
                    state_d     = ENTRY;
                    exc_valid_d = 1'b1;
                    exc_epc_d   = bus.pc;
                    if (sync_ev_s) begin
                        exc_cause_d = sync_cause_s;
                        exc_irq_d   = 3'd0;
                    end else begin
                        exc_cause_d = CAUSE_INT;
                        exc_irq_d   = irq_idx_s;
                    end
                end else if (req_s && armed_q) begin
                    mtc0_go_s = bus.mtc0_req;
                    eret_go_s = bus.eret_req;
                    if (bus.eret_req) begin
                        in_service_d = 1'b0;
                    end else begin
                        in_service_d = in_service_q;
                    end
                end else if (req_s) begin
                    // Strobes stay suppressed until the first edge after reset release.
                    stall_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ENTRY: begin
                stall_s = 1'b1;
                if (ack_take_s) begin
                    state_d      = FLUSH;
                    exc_valid_d  = 1'b0;
                    in_service_d = 1'b1;
                end else begin
                    state_d = ENTRY;
                end
            end
            FLUSH: begin
                stall_s = 1'b1;
                state_d = IDLE;
            end
            default: begin
                stall_s     = 1'b1;
                state_d     = IDLE;
                exc_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any entry in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= 5'd0;
            exc_irq_q    <= 3'd0;
            exc_epc_q    <= 32'd0;
            in_service_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            exc_valid_q  <= exc_valid_d;
            exc_cause_q  <= exc_cause_d;
            exc_irq_q    <= exc_irq_d;
            exc_epc_q    <= exc_epc_d;
            in_service_q <= in_service_d;
            armed_q      <= armed_d;
        end
    end

`ifdef EXC_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] svc_clr_s;

    // Latch rising edges of irq; a pending bit drops only when its entry is acknowledged.
    always_comb begin
        svc_clr_s = {NUM_IRQ{1'b0}};
        if (ack_take_s && (exc_cause_q == CAUSE_INT)) begin
            svc_clr_s[exc_irq_q] = 1'b1;
        end else begin
            svc_clr_s = {NUM_IRQ{1'b0}};
        end
        pending_d = (pending_q & ~svc_clr_s) | (bus.irq & ~irq_prev_q);
    end

    // Edge-detect sample and pending registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_prev_q <= {NUM_IRQ{1'b0}};
            pending_q  <= {NUM_IRQ{1'b0}};
        end else begin
            irq_prev_q <= bus.irq;
            pending_q  <= pending_d;
        end
    end

    assign pending_s = pending_q;
`else
    assign pending_s = bus.irq;
`endif

    assign bus.stall      = stall_s & rst;
    assign bus.mtc0_go    = mtc0_go_s & rst;
    assign bus.eret_go    = eret_go_s & rst;
    assign bus.exc_valid  = exc_valid_q;
    assign bus.exc_cause  = exc_cause_q;
    assign bus.exc_irq    = exc_irq_q;
    assign bus.exc_epc    = exc_epc_q;
    assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched: reset, sync priority, interrupts, strobe arbitration, mid-entry reset.
module tb_exc_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    exc_sched_if #(.NUM_IRQ(6)) bif ();

    exc_sched #(.NUM_IRQ(6), .ACK_WAIT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.inst_valid = 1'b0;
        bif.pc         = 32'd0;
        bif.syscall    = 1'b0;
        bif.brk        = 1'b0;
        bif.teq_hit    = 1'b0;
        bif.mtc0_req   = 1'b0;
        bif.eret_req   = 1'b0;
        bif.irq        = 6'd0;
        bif.cp0_ack    = 1'b0;
    endtask

    // From ENTRY: acknowledge, pass FLUSH, land in IDLE.
    task automatic do_ack();
        bif.cp0_ack = 1'b1;
        tick();
        bif.cp0_ack = 1'b0;
        tick();
    endtask

    task automatic do_eret();
        bif.eret_req = 1'b1;
        tick();
        bif.eret_req = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bif.status     = 32'h3;
        bif.inst_valid = 1'b1;
        bif.syscall    = 1'b1;
        bif.mtc0_req   = 1'b1;
        #1;
        total_cnt++;
        if (bif.stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bif.stall); else pass_cnt++;
        total_cnt++;
        if (bif.mtc0_go !== 1'b0) $display("FAIL reset_mtc0_go: got %b expected 0", bif.mtc0_go); else pass_cnt++;
        tick();
        total_cnt++;
        if ({bif.exc_valid, bif.exc_cause, bif.exc_irq, bif.in_service} !== 10'd0)
            $display("FAIL reset_regs: got %b expected 0", {bif.exc_valid, bif.exc_cause, bif.exc_irq, bif.in_service}); else pass_cnt++;
        total_cnt++;
        if (bif.exc_epc !== 32'd0) $display("FAIL reset_epc: got %h expected 0", bif.exc_epc); else pass_cnt++;
        clear_inputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_syscall();
        bif.status     = 32'h3;
        bif.inst_valid = 1'b1;
        bif.syscall    = 1'b1;
        bif.pc         = 32'h0040_0010;
        #1;
        total_cnt++;
        if (bif.stall !== 1'b1) $display("FAIL sys_stall_n: got %b expected 1", bif.stall); else pass_cnt++;
        total_cnt++;
        if (bif.exc_valid !== 1'b0) $display("FAIL sys_valid_n: got %b expected 0", bif.exc_valid); else pass_cnt++;
        tick();
        clear_inputs();
        total_cnt++;
        if (bif.exc_valid !== 1'b1) $display("FAIL sys_valid_n1: got %b expected 1", bif.exc_valid); else pass_cnt++;
        total_cnt++;
        if (bif.exc_cause !== 5'd8) $display("FAIL sys_cause: got %0d expected 8", bif.exc_cause); else pass_cnt++;
        total_cnt++;
        if (bif.exc_epc !== 32'h0040_0010) $display("FAIL sys_epc: got %h expected 00400010", bif.exc_epc); else pass_cnt++;
        tick();
        total_cnt++;
        if ({bif.exc_valid, bif.exc_cause, bif.stall} !== 7'b1_01000_1)
            $display("FAIL sys_hold: got %b expected 1010001", {bif.exc_valid, bif.exc_cause, bif.stall}); else pass_cnt++;
        tick();
        bif.cp0_ack = 1'b1;
        tick();
        bif.cp0_ack = 1'b0;
        total_cnt++;
        if ({bif.exc_valid, bif.stall, bif.in_service} !== 3'b011)
            $display("FAIL sys_flush: got %b expected 011", {bif.exc_valid, bif.stall, bif.in_service}); else pass_cnt++;
        tick();
        total_cnt++;
        if ({bif.stall, bif.in_service} !== 2'b01) $display("FAIL sys_idle: got %b expected 01", {bif.stall, bif.in_service}); else pass_cnt++;
        bif.eret_req = 1'b1;
        #1;
        total_cnt++;
        if ({bif.eret_go, bif.stall} !== 2'b10) $display("FAIL sys_eret_go: got %b expected 10", {bif.eret_go, bif.stall}); else pass_cnt++;
        tick();
        bif.eret_req = 1'b0;
        total_cnt++;
        if (bif.in_service !== 1'b0) $display("FAIL sys_eret_clear: got %b expected 0", bif.in_service); else pass_cnt++;
    endtask

    task automatic test_priority();
        bif.status     = 32'h7;
        bif.inst_valid = 1'b1;
        bif.syscall    = 1'b1;
        bif.brk        = 1'b1;
        tick();
        clear_inputs();
        total_cnt++;
        if (bif.exc_cause !== 5'd8) $display("FAIL prio_sys_over_bp: got %0d expected 8", bif.exc_cause); else pass_cnt++;
        do_ack();
        do_eret();
        bif.status     = 32'h5;
        bif.inst_valid = 1'b1;
        bif.syscall    = 1'b1;
        bif.brk        = 1'b1;
        tick();
        clear_inputs();
        total_cnt++;
        if (bif.exc_cause !== 5'd9) $display("FAIL prio_bp_sys_off: got %0d expected 9", bif.exc_cause); else pass_cnt++;
        do_ack();
        do_eret();
    endtask

    task automatic test_irq();
        bif.status = 32'h0000_0A01;
        bif.irq    = 6'b001010;
        #1;
        total_cnt++;
        if (bif.stall !== 1'b1) $display("FAIL irq_stall: got %b expected 1", bif.stall); else pass_cnt++;
        tick();
        total_cnt++;
        if ({bif.exc_cause, bif.exc_irq} !== {5'd0, 3'd1})
            $display("FAIL irq_lowest: got cause %0d irq %0d expected cause 0 irq 1", bif.exc_cause, bif.exc_irq); else pass_cnt++;
        bif.irq = 6'b001000;
        do_ack();
        #1;
        total_cnt++;
        if ({bif.stall, bif.in_service} !== 2'b01) $display("FAIL irq_masked_in_service: got %b expected 01", {bif.stall, bif.in_service}); else pass_cnt++;
        bif.eret_req = 1'b1;
        #1;
        total_cnt++;
        if (bif.eret_go !== 1'b1) $display("FAIL irq_eret_go: got %b expected 1", bif.eret_go); else pass_cnt++;
        tick();
        bif.eret_req = 1'b0;
        #1;
        total_cnt++;
        if (bif.stall !== 1'b1) $display("FAIL irq3_after_eret: got %b expected 1", bif.stall); else pass_cnt++;
        tick();
        total_cnt++;
        if ({bif.exc_valid, bif.exc_irq} !== {1'b1, 3'd3}) $display("FAIL irq3_index: got %b expected 1011", {bif.exc_valid, bif.exc_irq}); else pass_cnt++;
        bif.irq = 6'd0;
        do_ack();
        do_eret();
    endtask

    task automatic test_mtc0();
        bif.status  = 32'h9;
        bif.cp0_ack = 1'b1;
        tick();
        bif.cp0_ack = 1'b0;
        total_cnt++;
        if ({bif.exc_valid, bif.in_service, bif.stall} !== 3'b000)
            $display("FAIL ack_idle_ignored: got %b expected 000", {bif.exc_valid, bif.in_service, bif.stall}); else pass_cnt++;
        bif.inst_valid = 1'b1;
        bif.teq_hit    = 1'b1;
        bif.mtc0_req   = 1'b1;
        #1;
        total_cnt++;
        if ({bif.mtc0_go, bif.stall} !== 2'b01) $display("FAIL mtc0_lose_to_event: got %b expected 01", {bif.mtc0_go, bif.stall}); else pass_cnt++;
        tick();
        bif.inst_valid = 1'b0;
        bif.teq_hit    = 1'b0;
        total_cnt++;
        if ({bif.exc_cause, bif.mtc0_go} !== {5'd13, 1'b0})
            $display("FAIL mtc0_entry_cause: got cause %0d go %b expected cause 13 go 0", bif.exc_cause, bif.mtc0_go); else pass_cnt++;
        bif.cp0_ack = 1'b1;
        tick();
        bif.cp0_ack = 1'b0;
        total_cnt++;
        if ({bif.mtc0_go, bif.stall} !== 2'b01) $display("FAIL mtc0_flush_held: got %b expected 01", {bif.mtc0_go, bif.stall}); else pass_cnt++;
        tick();
        total_cnt++;
        if ({bif.mtc0_go, bif.stall} !== 2'b10) $display("FAIL mtc0_go_after_flush: got %b expected 10", {bif.mtc0_go, bif.stall}); else pass_cnt++;
        bif.mtc0_req = 1'b0;
        do_eret();
    endtask

    task automatic test_reset_mid_entry();
        bif.status     = 32'h3;
        bif.inst_valid = 1'b1;
        bif.syscall    = 1'b1;
        bif.pc         = 32'h0000_1234;
        tick();
        clear_inputs();
        total_cnt++;
        if (bif.exc_valid !== 1'b1) $display("FAIL mid_entry_valid: got %b expected 1", bif.exc_valid); else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({bif.exc_valid, bif.stall, bif.exc_cause, bif.in_service} !== 8'd0)
            $display("FAIL mid_entry_reset_outs: got %b expected 0", {bif.exc_valid, bif.stall, bif.exc_cause, bif.in_service}); else pass_cnt++;
        total_cnt++;
        if (bif.exc_epc !== 32'd0) $display("FAIL mid_entry_reset_epc: got %h expected 0", bif.exc_epc); else pass_cnt++;
        bif.mtc0_req = 1'b1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({bif.mtc0_go, bif.stall} !== 2'b01) $display("FAIL release_no_strobe: got %b expected 01", {bif.mtc0_go, bif.stall}); else pass_cnt++;
        tick();
        total_cnt++;
        if ({bif.mtc0_go, bif.exc_valid} !== 2'b10) $display("FAIL release_then_strobe: got %b expected 10", {bif.mtc0_go, bif.exc_valid}); else pass_cnt++;
        bif.mtc0_req = 1'b0;
        tick();
        total_cnt++;
        if (bif.exc_valid !== 1'b0) $display("FAIL release_no_entry: got %b expected 0", bif.exc_valid); else pass_cnt++;
    endtask

    task automatic test_irq_hold();
        bif.status = 32'h0000_0101;
        bif.irq    = 6'b000001;
`ifdef EXC_IRQ_EDGE_EN
        tick();
`endif
        tick();
        total_cnt++;
        if ({bif.exc_valid, bif.exc_cause, bif.exc_irq} !== 9'b1_00000_000)
            $display("FAIL hold_first_entry: got %b expected 100000000", {bif.exc_valid, bif.exc_cause, bif.exc_irq}); else pass_cnt++;
        do_ack();
        do_eret();
        #1;
`ifdef EXC_IRQ_EDGE_EN
        total_cnt++;
        if (bif.stall !== 1'b0) $display("FAIL hold_no_reentry: got %b expected 0", bif.stall); else pass_cnt++;
`else
        total_cnt++;
        if (bif.stall !== 1'b1) $display("FAIL hold_reentry: got %b expected 1", bif.stall); else pass_cnt++;
        tick();
        bif.irq = 6'd0;
        do_ack();
        do_eret();
`endif
        bif.irq = 6'd0;
        tick();
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_priority();
        test_irq();
        test_mtc0();
        test_reset_mid_entry();
        test_irq_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
